// File: rtl/adder64_sched_pkg.sv
// adder64_sched_pkg: data width, default latency/requester count and a
// one-hot index helper shared by the adder scheduler files.
package adder64_sched_pkg;

    localparam int LEN_DATA       = 64;
    localparam int ADD_LAT        = 9;
    localparam int ADD_SCHED_NREQ = 4;
    localparam int MAX_NREQ       = 8;

    typedef logic [LEN_DATA-1:0] data_t;

    // Index of the set bit of a one-hot vector; 0 when nothing is set.
    function automatic logic [2:0] oh_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/adder64_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the search starts at ptr and
// wraps, so the returned grant is the first requester at or after ptr.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder64_sched.sv
// adder64_sched: round-robin scheduler sharing one pipelined adder among NREQ
// requesters. Optional ADD_SCHED_SUB_EN adds req_sub for a - b operations.
module adder64_sched
    import adder64_sched_pkg::*;
#(
    parameter int NREQ  = ADD_SCHED_NREQ,
    parameter int LAT   = ADD_LAT,
    parameter int IDW   = $clog2(NREQ),
    localparam int CNTW = $clog2(LAT + 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*LEN_DATA-1:0] req_a,
    input  logic [NREQ*LEN_DATA-1:0] req_b,
    input  logic [NREQ-1:0]          req_cin,
`ifdef ADD_SCHED_SUB_EN
    input  logic [NREQ-1:0]          req_sub,
`endif
    input  logic                     hold,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          res_valid,
    output logic [LEN_DATA-1:0]      res_sum,
    output logic                     res_cout,
    output logic [CNTW-1:0]          inflight,
    output logic                     idle,
    output logic                     err,
    output logic                     add_en,
    output logic                     add_valid,
    output logic [LEN_DATA-1:0]      add_a,
    output logic [LEN_DATA-1:0]      add_b,
    output logic                     add_cin,
    input  logic [LEN_DATA-1:0]      add_sum,
    input  logic                     add_cout,
    input  logic                     add_rdy
);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] arb_gnt;
    logic            grant;
    logic [IDW-1:0]  gnt_idx;
    data_t           sel_a;
    data_t           sel_b;
    logic            sel_cin;

    logic            iss_v;
    data_t           iss_a;
    data_t           iss_b;
    logic            iss_cin;
    logic [IDW-1:0]  iss_id;

    logic            tag_v  [LAT];
    logic [IDW-1:0]  tag_id [LAT];
    logic            v_exit;
    logic [IDW-1:0]  id_exit;

    rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    assign gnt     = (hold || rst) ? '0 : arb_gnt;
    assign grant   = |gnt;
    assign gnt_idx = IDW'(oh_to_idx(MAX_NREQ'(gnt)));

    always_comb begin
        sel_a   = req_a[int'(gnt_idx)*LEN_DATA +: LEN_DATA];
        sel_b   = req_b[int'(gnt_idx)*LEN_DATA +: LEN_DATA];
        sel_cin = req_cin[gnt_idx];
`ifdef ADD_SCHED_SUB_EN
        // Two's-complement subtract: a + ~b + 1; cout then means "no borrow".
        if (req_sub[gnt_idx]) begin
            sel_b   = ~sel_b;
            sel_cin = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            iss_v   <= 1'b0;
            iss_a   <= '0;
            iss_b   <= '0;
            iss_cin <= 1'b0;
            iss_id  <= '0;
        end else begin
            iss_v <= grant;
            if (grant) begin
                ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                iss_a   <= sel_a;
                iss_b   <= sel_b;
                iss_cin <= sel_cin;
                iss_id  <= gnt_idx;
            end
        end
    end

    // Tag pipeline mirrors the adder's rdy pipeline; it never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= iss_v;
            tag_id[0] <= iss_id;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign v_exit  = tag_v[LAT-1];
    assign id_exit = tag_id[LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (add_rdy != v_exit) err <= 1'b1;
            case ({iss_v, v_exit})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        res_valid = '0;
        if (add_rdy && v_exit) res_valid[id_exit] = 1'b1;
    end

    assign res_sum   = add_sum;
    assign res_cout  = add_cout;
    assign add_en    = 1'b1;
    assign add_valid = iss_v;
    assign add_a     = iss_a;
    assign add_b     = iss_b;
    assign add_cin   = iss_cin;
    assign idle      = (inflight == '0) && !iss_v;

endmodule

// File: tb/tb_adder64_sched.sv
// tb_adder64_sched: drives adder64_sched with a behavioural adder attached and
// compares every cycle against a queue-based model of grants and returns.
module tb_adder64_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 9;
  localparam int W    = 64;

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
`ifdef ADD_SCHED_SUB_EN
  logic [NREQ-1:0]   req_sub;
`endif
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   res_valid;
  logic [W-1:0]      res_sum;
  logic              res_cout;
  logic [3:0]        inflight;
  logic              idle;
  logic              err;
  logic              add_en;
  logic              add_valid;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_cin;
  logic [W-1:0]      add_sum;
  logic              add_cout;
  logic              add_rdy;

  logic [W-1:0] op_a   [NREQ];
  logic [W-1:0] op_b   [NREQ];
  logic         op_cin [NREQ];
  logic         op_sub [NREQ];

  exp_t            exp_q[$];
  logic [NREQ-1:0] gnt_log[$];
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              m_ptr = 0;
  int              peak = 0;
  int              last_rv_cyc = -1;
  logic [NREQ-1:0] last_rv;
  logic [NREQ-1:0] last_gnt;
  logic [W-1:0]    last_sum;
  logic            last_cout;

  always #5 clk = ~clk;

  always_comb begin
    req_a   = '0;
    req_b   = '0;
    req_cin = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_cin[i]      = op_cin[i];
    end
  end

`ifdef ADD_SCHED_SUB_EN
  always_comb begin
    req_sub = '0;
    for (int i = 0; i < NREQ; i++) req_sub[i] = op_sub[i];
  end
`endif

  // Behavioural shared adder: LAT-deep pipeline, rdy tracks valid.
  logic [LAT-1:0] am_v;
  logic [W-1:0]   am_sum  [LAT];
  logic           am_cout [LAT];

  always @(posedge clk) begin
    if (rst) am_v <= '0;
    else     am_v <= {am_v[LAT-2:0], add_valid};
    if (add_en) begin
      {am_cout[0], am_sum[0]} <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
      for (int i = 1; i < LAT; i++) begin
        am_sum[i]  <= am_sum[i-1];
        am_cout[i] <= am_cout[i-1];
      end
    end
  end

  assign add_rdy  = am_v[LAT-1];
  assign add_sum  = am_sum[LAT-1];
  assign add_cout = am_cout[LAT-1];

  adder64_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADD_SCHED_SUB_EN
    .req_sub   (req_sub),
`endif
    .hold      (hold),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .inflight  (inflight),
    .idle      (idle),
    .err       (err),
    .add_en    (add_en),
    .add_valid (add_valid),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .add_rdy   (add_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One cycle: drive inputs, check all outputs against the model, advance.
  task automatic tick(input logic [NREQ-1:0] r, input logic h, input logic rs, output int g_out);
    logic [NREQ-1:0] g_exp;
    logic [NREQ-1:0] rv_exp;
    logic [W:0]      full;
    int              gi;
    int              n_inf;
    logic            iss_exp;
    req  = r;
    hold = h;
    rst  = rs;
    #2;
    gi = -1;
    g_exp = '0;
    if (!h && !rs) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (gi < 0 && r[idx]) gi = idx;
      end
    end
    if (gi >= 0) g_exp[gi] = 1'b1;
    chk("gnt", gnt, g_exp);
    chk("ptr", dut.ptr, m_ptr);
    last_gnt = gnt;
    if (gnt != '0) gnt_log.push_back(gnt);

    rv_exp  = '0;
    n_inf   = 0;
    iss_exp = 1'b0;
    foreach (exp_q[i]) begin
      if (exp_q[i].due - LAT + 1 <= cyc) n_inf++;
      if (exp_q[i].due - LAT == cyc) iss_exp = 1'b1;
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      rv_exp[exp_q[0].id] = 1'b1;
      chk("res_sum", res_sum, exp_q[0].sum);
      chk("res_cout", res_cout, exp_q[0].cout);
    end
    chk("res_valid", res_valid, rv_exp);
    chk("add_valid", add_valid, iss_exp);
    chk("inflight", inflight, n_inf);
    chk("idle", idle, (n_inf == 0) && !iss_exp);
    chk("err", err, 1'b0);
    if (int'(inflight) > peak) peak = int'(inflight);
    if (res_valid != '0) begin
      last_rv_cyc = cyc;
      last_rv     = res_valid;
      last_sum    = res_sum;
      last_cout   = res_cout;
    end

    if (rs) begin
      exp_q.delete();
      m_ptr = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
      if (gi >= 0) begin
        if (op_sub[gi]) begin
          full = {(op_a[gi] < op_b[gi]) ? 1'b0 : 1'b1, op_a[gi] - op_b[gi]};
        end else begin
          full = (W+1)'(op_a[gi]) + (W+1)'(op_b[gi]) + (W+1)'(op_cin[gi]);
        end
        exp_q.push_back('{due: cyc + 1 + LAT, id: gi, sum: full[W-1:0], cout: full[W]});
        m_ptr = (gi + 1) % NREQ;
      end
    end
    g_out = gi;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int              gd;
    int              c0;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] order_tab [8];
    order_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_cin[i] = 1'b0; op_sub[i] = 1'b0;
    end
    rst  = 1'b1;
    hold = 1'b0;
    req  = '1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with all requesters asserted
    chk("rst_gnt", gnt, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    chk("rst_ptr", dut.ptr, 0);
    tick('1, 1'b0, 1'b1, gd);

    // Single op on requester 2
    op_a[2] = 64'd5; op_b[2] = 64'd7; op_cin[2] = 1'b1;
    c0 = cyc;
    tick(4'b0100, 1'b0, 1'b0, gd);
    repeat (12) tick('0, 1'b0, 1'b0, gd);
    chk("single_latency", last_rv_cyc - c0, 10);
    chk("single_owner", last_rv, 4'b0100);
    chk("single_sum", last_sum, 13);
    chk("single_cout", last_cout, 0);

    // Carry-out on requester 3 (leaves ptr at 0)
    op_a[3] = '1; op_b[3] = 64'd1; op_cin[3] = 1'b0;
    tick(4'b1000, 1'b0, 1'b0, gd);
    repeat (12) tick('0, 1'b0, 1'b0, gd);
    chk("carry_sum", last_sum, 0);
    chk("carry_cout", last_cout, 1);

    // Full contention
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = {$urandom, $urandom}; op_b[i] = {$urandom, $urandom}; op_cin[i] = 1'($urandom_range(0, 1));
    end
    peak = 0;
    gnt_log.delete();
    repeat (10) tick(4'b1111, 1'b0, 1'b0, gd);
    repeat (12) tick('0, 1'b0, 1'b0, gd);
    for (int i = 0; i < 8; i++) chk("contention_order", gnt_log[i], order_tab[i]);
    chk("contention_peak", peak, LAT);

    // Hold blocks grants; requester 0 wins after release
    repeat (5) tick(4'b0011, 1'b1, 1'b0, gd);
    tick(4'b0011, 1'b0, 1'b0, gd);
    chk("hold_first_grant", last_gnt, 4'b0001);
    repeat (12) tick('0, 1'b0, 1'b0, gd);

    // Reset mid-flight
    repeat (3) tick(4'b0111, 1'b0, 1'b0, gd);
    tick('0, 1'b0, 1'b0, gd);
    last_rv_cyc = -1;
    tick('0, 1'b0, 1'b1, gd);
    repeat (14) tick('0, 1'b0, 1'b0, gd);
    chk("rst_flight_no_result", last_rv_cyc, -1);
    chk("rst_flight_inflight", inflight, 0);
    chk("rst_flight_ptr", dut.ptr, 0);
    chk("rst_flight_err", err, 0);

`ifdef ADD_SCHED_SUB_EN
    op_a[0] = 64'd10; op_b[0] = 64'd3; op_sub[0] = 1'b1;
    tick(4'b0001, 1'b0, 1'b0, gd);
    repeat (12) tick('0, 1'b0, 1'b0, gd);
    chk("sub_pos_sum", last_sum, 7);
    chk("sub_pos_cout", last_cout, 1);
    op_a[1] = 64'd3; op_b[1] = 64'd10; op_sub[1] = 1'b1;
    tick(4'b0010, 1'b0, 1'b0, gd);
    repeat (12) tick('0, 1'b0, 1'b0, gd);
    chk("sub_neg_sum", last_sum, 64'hFFFF_FFFF_FFFF_FFF9);
    chk("sub_neg_cout", last_cout, 0);
`endif

    // Randomized requesters that hold until granted
    pend = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          op_a[i]   = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
          op_b[i]   = {$urandom, $urandom};
          op_cin[i] = 1'($urandom_range(0, 1));
`ifdef ADD_SCHED_SUB_EN
          op_sub[i] = 1'($urandom_range(0, 1));
`endif
        end
      end
      tick(pend, ($urandom_range(0, 7) == 0), 1'b0, gd);
      if (gd >= 0) pend[gd] = 1'b0;
    end
    repeat (12) tick('0, 1'b0, 1'b0, gd);
    chk("final_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
